// File: rtl/vga_frame_monitor.sv
// Passive pixel-bus checker: measures active width/height of each frame and
// folds its pixels into a 16-bit rotating signature, reported at every frame start.
module vga_frame_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        de,
  input  logic [2:0]  rgb_r,
  input  logic [2:0]  rgb_g,
  input  logic [1:0]  rgb_b,
  output logic [9:0]  meas_width,
  output logic [9:0]  meas_height,
  output logic [15:0] signature,
  output logic        width_err,
  output logic        dims_ok,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned CW = 10;
  localparam int unsigned SW = 16;
  localparam int unsigned PW = 8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   pix_c;
  logic            de_q;
  logic            sof_c, line_start_c, line_end_c;
  logic            seed_c, commit_c;
  logic [CW-1:0]   pix_cnt, line_cnt, first_w;
  logic            werr;
  logic [SW-1:0]   cs;
  logic [CW-1:0]   close_first_w_c;
  logic            close_werr_c;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == '1) ? x : x + CW'(1);
  endfunction

  assign pix_c        = {rgb_r, rgb_g, rgb_b};
  assign sof_c        = de & (hcount == '0) & (vcount == '0);
  assign line_start_c = de & ~de_q;
  assign line_end_c   = ~de & de_q;

  // A sof arriving with de still high closes the open line with the line-end rule
  assign close_first_w_c = (de_q && (line_cnt == CW'(1))) ? pix_cnt : first_w;
  assign close_werr_c    = werr | (de_q && (line_cnt != CW'(1)) && (pix_cnt != first_w));

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    seed_c   = 1'b0;
    commit_c = 1'b0;
    case (state)
      IDLE: begin
        if (sof_c) begin
          seed_c   = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sof_c) begin
          seed_c   = 1'b1;
          commit_c = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-frame accumulators
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      de_q     <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      first_w  <= '0;
      werr     <= 1'b0;
      cs       <= '0;
    end else begin
      de_q <= de;
      if (seed_c) begin
        cs       <= {8'h00, pix_c};
        pix_cnt  <= CW'(1);
        line_cnt <= CW'(1);
        werr     <= 1'b0;
      end else if (state == ACTIVE) begin
        if (line_end_c) begin
          if (line_cnt == CW'(1))     first_w <= pix_cnt;
          else if (pix_cnt != first_w) werr   <= 1'b1;
        end
        if (de) begin
          cs <= {cs[SW-2:0], cs[SW-1]} ^ {8'h00, pix_c};
          if (line_start_c) begin
            line_cnt <= sat_inc(line_cnt);
            pix_cnt  <= CW'(1);
          end else begin
            pix_cnt  <= sat_inc(pix_cnt);
          end
        end
      end
    end
  end

  // Published results of the last completed frame
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      meas_width  <= '0;
      meas_height <= '0;
      signature   <= '0;
      width_err   <= 1'b0;
      dims_ok     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= commit_c;
      if (commit_c) begin
        meas_width  <= close_first_w_c;
        meas_height <= line_cnt;
        signature   <= cs;
        width_err   <= close_werr_c;
        dims_ok     <= (close_first_w_c == CW'(H_ACTIVE)) &&
                       (line_cnt == CW'(V_ACTIVE)) && !close_werr_c;
        frame_count <= frame_count + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a small 8x4 raster: frame expectations
// are queued when the next sof is driven and compared on every frame_done pulse.
module tb_vga_frame_monitor;

  localparam int HA   = 8;
  localparam int VA   = 4;
  localparam int BARS = 0;
  localparam int ZERO = 1;
  localparam int ONE  = 2;

  logic        clk_pix = 1'b0;
  logic        reset   = 1'b0;
  logic [9:0]  hcount  = '0;
  logic [9:0]  vcount  = '0;
  logic        de      = 1'b0;
  logic [2:0]  rgb_r   = '0;
  logic [2:0]  rgb_g   = '0;
  logic [1:0]  rgb_b   = '0;
  logic [9:0]  meas_width;
  logic [9:0]  meas_height;
  logic [15:0] signature;
  logic        width_err;
  logic        dims_ok;
  logic        frame_done;
  logic [15:0] frame_count;

  typedef struct {
    logic [9:0]  w;
    logic [9:0]  h;
    logic [15:0] sig;
    logic        werr;
    logic        ok;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  exp_t        got_e;
  bit          pend_valid = 1'b0;
  logic [15:0] cnt_model  = '0;
  int          n_checks   = 0;
  int          n_err      = 0;

  vga_frame_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk_pix     (clk_pix),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .de          (de),
    .rgb_r       (rgb_r),
    .rgb_g       (rgb_g),
    .rgb_b       (rgb_b),
    .meas_width  (meas_width),
    .meas_height (meas_height),
    .signature   (signature),
    .width_err   (width_err),
    .dims_ok     (dims_ok),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic d, input int h, input int v, input logic [7:0] p);
    de     = d;
    hcount = 10'(h);
    vcount = 10'(v);
    {rgb_r, rgb_g, rgb_b} = p;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    de    = 1'b0;
    #1;
    check({tag, "_width"},  32'(meas_width),  32'd0);
    check({tag, "_height"}, 32'(meas_height), 32'd0);
    check({tag, "_sig"},    32'(signature),   32'd0);
    check({tag, "_werr"},   32'(width_err),   32'd0);
    check({tag, "_ok"},     32'(dims_ok),     32'd0);
    check({tag, "_done"},   32'(frame_done),  32'd0);
    check({tag, "_count"},  32'(frame_count), 32'd0);
    @(posedge clk_pix);
    #1;
    reset      = 1'b0;
    pend_valid = 1'b0;
    cnt_model  = '0;
  endtask

  // The previous frame is complete once the next sof is driven
  task automatic begin_frame();
    if (pend_valid) begin
      cnt_model = cnt_model + 16'd1;
      pend.cnt  = cnt_model;
      sb.push_back(pend);
      pend_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input int nl, input int w, input int odd_line, input int odd_w,
                           input int mode, input int hbl, input int vbl,
                           input int abort_line, input bit stuck_end);
    logic [15:0] sig;
    logic [7:0]  p;
    int          w0;
    int          lw;
    bit          werr;
    sig  = '0;
    w0   = 0;
    werr = 1'b0;
    for (int y = 0; y < nl; y++) begin
      lw = (y == odd_line) ? odd_w : w;
      if (y == 0) w0 = lw;
      else if (lw != w0) werr = 1'b1;
      for (int x = 0; x < lw; x++) begin
        case (mode)
          BARS:    p = 8'(((x % 8) * 37) + y);
          ZERO:    p = 8'h00;
          default: p = (x == 0 && y == 0) ? 8'hFF : 8'h00;
        endcase
        if (x == 0 && y == 0) begin
          begin_frame();
          sig = {8'h00, p};
        end else begin
          sig = {sig[14:0], sig[15]} ^ {8'h00, p};
        end
        drive(1'b1, x, y, p);
        if (y == abort_line && x == 2) begin
          apply_reset("mid_reset");
          return;
        end
      end
      if (!(stuck_end && y == nl - 1))
        for (int k = 0; k < hbl; k++) drive(1'b0, lw + k, y, 8'h00);
    end
    if (!stuck_end)
      for (int k = 0; k < vbl * (w + hbl); k++)
        drive(1'b0, k % (w + hbl), nl + k / (w + hbl), 8'h00);
    pend = '{w: 10'(w0), h: 10'(nl), sig: sig, werr: werr,
             ok: (w0 == HA && nl == VA && !werr), cnt: 16'd0};
    pend_valid = 1'b1;
  endtask

  // Every frame_done must match the oldest queued frame expectation
  always @(negedge clk_pix) begin
    if (frame_done) begin
      if (sb.size() == 0) begin
        check("spurious_frame_done", 32'(frame_done), 32'd0);
      end else begin
        got_e = sb.pop_front();
        check("meas_width",  32'(meas_width),  32'(got_e.w));
        check("meas_height", 32'(meas_height), 32'(got_e.h));
        check("signature",   32'(signature),   32'(got_e.sig));
        check("width_err",   32'(width_err),   32'(got_e.werr));
        check("dims_ok",     32'(dims_ok),     32'(got_e.ok));
        check("frame_count", 32'(frame_count), 32'(got_e.cnt));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] p;
    #3;
    apply_reset("init");
    repeat (3) drive(1'b0, 0, 5, 8'h00);

    run_frame(4, 8, -1, 0, BARS, 4, 2, -1, 1'b0);
    run_frame(4, 8, -1, 0, BARS, 4, 2, -1, 1'b0);
    run_frame(4, 8, -1, 0, ZERO, 4, 2, -1, 1'b0);
    run_frame(4, 8, -1, 0, ONE,  4, 2, -1, 1'b0);
    run_frame(4, 8,  2, 7, BARS, 4, 2, -1, 1'b0);
    run_frame(4, 8, -1, 0, BARS, 1, 0, -1, 1'b0);
    run_frame(5, 10, -1, 0, BARS, 1, 0, -1, 1'b0);
    run_frame(4, 8,  3, 9, BARS, 2, 0, -1, 1'b1);

    run_frame(4, 8, -1, 0, BARS, 2, 1, -1, 1'b0);
    run_frame(4, 8, -1, 0, BARS, 2, 1, -1, 1'b0);
    run_frame(4, 8, -1, 0, BARS, 2, 1,  1, 1'b0);
    run_frame(4, 8, -1, 0, BARS, 2, 1, -1, 1'b0);
    run_frame(4, 8, -1, 0, BARS, 2, 1, -1, 1'b0);
    repeat (4) drive(1'b0, 0, 6, 8'h00);

    // One-pixel frames with de held high: every cycle is a sof
    apply_reset("pre_wrap");
    for (int i = 0; i < 65537; i++) begin
      p = 8'(i);
      begin_frame();
      pend = '{w: 10'd1, h: 10'd1, sig: {8'h00, p}, werr: 1'b0, ok: 1'b0, cnt: 16'd0};
      pend_valid = 1'b1;
      drive(1'b1, 0, 0, p);
    end
    check("wrap_count", 32'(frame_count), 32'h0000);
    check("wrap_done",  32'(frame_done),  32'd1);
    repeat (4) drive(1'b0, 1, 1, 8'h00);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Passive checker that sits on the pixel bus between the test pattern generator and the VGA output pins. It consumes the generator's RGB stream together with `de`, `hcount` and `vcount`, and measures each frame's active width and height. It computes a per-frame 16-bit signature over the pixel data. At each frame boundary it publishes the completed frame's results, letting hardware self-test and simulation confirm the pattern without a monitor attached.

## Interface
- `H_ACTIVE`, default 640: expected active pixels per line.
- `V_ACTIVE`, default 480: expected active lines per frame.
- `clk_pix` in 1: pixel clock, ~25 MHz. This is the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `hcount` in 10: horizontal position from the timing generator.
- `vcount` in 10: vertical position from the timing generator.
- `de` in 1: data enable; high during the active area.
- `rgb_r` in 3: red pixel component.
- `rgb_g` in 3: green pixel component.
- `rgb_b` in 2: blue pixel component.
- `meas_width` out 10: width of the first line of the last completed frame.
- `meas_height` out 10: number of lines in the last completed frame.
- `signature` out 16: pixel signature of the last completed frame.
- `width_err` out 1: some line in the last frame differed in width from that frame's first line.
- `dims_ok` out 1: last frame matched `H_ACTIVE`×`V_ACTIVE` and `width_err` is 0.
- `frame_done` out 1: one-cycle pulse when the results above update.
- `frame_count` out 16: number of completed frames; wraps.

## Operation
- Pixel: `pix[7:0] = {rgb_r, rgb_g, rgb_b}`.
- `sof` (start of frame) = `de & (hcount==0) & (vcount==0)`.
- `de_q` is `de` registered. Line start = `de & ~de_q`. Line end = `~de & de_q`.
- States:
  - IDLE: after reset, waiting for the first `sof`.
  - ACTIVE: accumulating a frame.
- IDLE → ACTIVE on `sof`. Accumulators are seeded from the `sof` pixel. No `frame_done` is produced for this transition.
- ACTIVE on `sof`:
  - Commit the accumulated frame to the outputs and pulse `frame_done`.
  - Increment `frame_count`.
  - Reseed the accumulators with the current pixel; it belongs to the new frame.
- Accumulators:
  - `pix_cnt` (10 b): current line width; saturates at 1023.
  - `line_cnt` (10 b): lines in frame; saturates at 1023.
  - `first_w` (10 b): width of the first line.
  - `werr`: sticky per frame.
  - `cs` (16 b): running signature.
- Every cycle with `de`=1: `cs <= {cs[14:0], cs[15]} ^ {8'h00, pix}`, and `pix_cnt` increments.
- Seeding at `sof`: `cs <= {8'h00, pix}`, `pix_cnt <= 1`, `line_cnt <= 1`, `werr <= 0`.
- Line start (not `sof`): `line_cnt` increments and `pix_cnt <= 1`.
- Line end:
  - If `line_cnt==1`, set `first_w <= pix_cnt`.
  - Otherwise, if `pix_cnt != first_w`, set `werr <= 1`.
- Stuck-high `de`: if `sof` arrives while `de_q`=1 (no line end was seen), the open line is closed using the same rule as a line end before committing.
- Commit values:
  - `meas_width <= first_w`
  - `meas_height <= line_cnt`
  - `signature <= cs`
  - `width_err <= werr`
  - `dims_ok <= (first_w==H_ACTIVE) & (line_cnt==V_ACTIVE) & ~werr`
- Pixels with `de`=0 never affect `cs` or the counters.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, and all accumulators are 0.
- Latency: results from the frame ending before a `sof` sampled at edge N are visible after edge N. `frame_done` is high for exactly one cycle starting at edge N.
- Reset asserted mid-frame: outputs clear immediately (asynchronously) and state returns to IDLE. The next `sof` produces no `frame_done`, and `frame_count` restarts at 0.
- `frame_count` wraps from 0xFFFF to 0x0000.
- Back-to-back frames with no vertical blanking are legal: a line end and a `sof` may fall on adjacent cycles.

## Test plan
- **Nominal 640×480:** run two frames of colour bars with standard timing. Expect one `frame_done` pulse (on the second `sof`), `meas_width`=640, `meas_height`=480, `dims_ok`=1, `width_err`=0, `frame_count`=1.
- **Small 8×4 all-zero frame** (`H_ACTIVE`=8, `V_ACTIVE`=4): expect `signature`=0x0000 and `dims_ok`=1.
- **Single non-zero pixel:** same 8×4 frame with only the `sof` pixel = 0xFF. After 31 zero pixels, expect `signature`=0x807F.
- **Short line:** 8×4 frame whose line 3 has 7 pixels. Expect `width_err`=1, `dims_ok`=0, `meas_width`=8, `meas_height`=4. The next clean frame reports `width_err`=0.
- **Reset mid-frame:** assert `reset` during line 2 of frame 3. Expect all outputs = 0 at once, no `frame_done` on the next `sof`, and the first post-reset report shows `frame_count`=1.
- **Counter wrap:** preload or run to `frame_count`=0xFFFF, then complete one more frame. Expect `frame_count`=0x0000 and a `frame_done` pulse.
